// File: rtl/fifo_byte_packer.sv
// fifo_byte_packer: drains a byte FIFO and packs BYTES consecutive bytes into one word on a valid/ready port.
// Define FIFO_PACKER_TIMEOUT_EN to flush a partial word after TIMEOUT idle cycles.
module fifo_byte_packer #(
    parameter int BYTES   = 4,
    parameter int RD_LAT  = 0,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_is_empty,
    input  logic [7:0]             fifo_read_data,
    output logic                   fifo_read_ctrl,
    output logic                   out_valid,
    input  logic                   in_ready,
    output logic [8*BYTES-1:0]     out_word,
    output logic [$clog2(BYTES):0] out_bytes
);
    localparam int CW = $clog2(BYTES) + 1;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic [8*BYTES-1:0] word_q, word_d;

    logic               readCtrl;
    logic               capture;
    logic               lastLane;
    logic               handshake;
    logic               flush;
    logic [CW:0]        inFlight;

    if (BYTES < 2 || BYTES > 8 || (BYTES & (BYTES - 1)) != 0 ||
        RD_LAT < 0 || RD_LAT > 1 || TIMEOUT < 1) begin : gBadParams
        $error("fifo_byte_packer: unsupported parameter combination");
    end

    // A read is only issued when a lane is free for it, counting a byte still in flight.
    always_comb begin
        inFlight  = {1'b0, cnt_q} + {{CW{1'b0}}, pending_q};
        handshake = (state_q == HOLD) && in_ready;
        readCtrl  = !rst && !fifo_is_empty && (inFlight < (CW+1)'(BYTES)) &&
                    ((state_q == FILL) || handshake);
        capture   = (RD_LAT == 0) ? readCtrl : pending_q;
        lastLane  = capture && (state_q == FILL) && (cnt_q == CW'(BYTES - 1));
        pending_d = (RD_LAT != 0) && readCtrl;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (lastLane || flush) state_d = HOLD;
            HOLD:    if (in_ready) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // On a handshake the word restarts from lane 0, so a byte captured on that edge lands in lane 0.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (handshake) begin
            word_d = '0;
            cnt_d  = '0;
        end
        if (capture) begin
            for (int i = 0; i < BYTES; i++) begin
                if (cnt_d == CW'(i)) word_d[8*i +: 8] = fifo_read_data;
            end
            cnt_d = (cnt_d == CW'(BYTES - 1)) ? '0 : cnt_d + CW'(1);
        end
        if (flush) cnt_d = '0;
    end

    always_comb begin
        fifo_read_ctrl = readCtrl;
        out_valid      = (state_q == HOLD);
        out_word       = word_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            word_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            word_q    <= word_d;
        end
    end

`ifdef FIFO_PACKER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [IW-1:0] idle_q, idle_d;
    logic [CW-1:0] bytes_q, bytes_d;
    logic          idleTick;

    // Idle time only accrues while a partial word sits with nothing in flight and nothing to read.
    always_comb begin
        idleTick = (state_q == FILL) && (cnt_q != '0) && !pending_q && fifo_is_empty;
        flush    = idleTick && (idle_q == IW'(TIMEOUT - 1));
        idle_d   = idle_q;
        if (capture || handshake || flush) begin
            idle_d = '0;
        end else if (idleTick) begin
            idle_d = idle_q + IW'(1);
        end
        bytes_d = bytes_q;
        if (lastLane) begin
            bytes_d = CW'(BYTES);
        end else if (flush) begin
            bytes_d = cnt_q;
        end else if (handshake) begin
            bytes_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q  <= '0;
            bytes_q <= '0;
        end else begin
            idle_q  <= idle_d;
            bytes_q <= bytes_d;
        end
    end

    assign out_bytes = bytes_q;
`else
    assign flush     = 1'b0;
    assign out_bytes = (state_q == HOLD) ? CW'(BYTES) : '0;
`endif

    assert property (@(posedge clk) disable iff (rst)
        out_valid && !in_ready |=> out_valid && $stable(out_word) && $stable(out_bytes));

    assert property (@(posedge clk) disable iff (rst) cnt_q < CW'(BYTES));

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Testbench for fifo_byte_packer: packers with RD_LAT 0 and 1 are fed by behavioural byte FIFOs
// carrying the same byte stream, and a free-running monitor checks their words against a scoreboard.
`timescale 1ns/1ps
module tb_fifo_byte_packer;
    localparam int BYTES = 4;
    localparam int LANES = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   inReady;
    logic [LANES-1:0]       fifoEmpty;
    logic [LANES-1:0][7:0]  fifoData;
    logic [LANES-1:0]       rdCtrl;
    logic [LANES-1:0]       outValid;
    logic [LANES-1:0][31:0] outWord;
    logic [LANES-1:0][2:0]  outBytes;

    logic [7:0]  stimQ[$];
    logic [31:0] expWordQ[$];
    logic [2:0]  expBytesQ[$];
    int          discardPtr = 0;
    bit          gapMode = 1'b0;

    int rdPtr[LANES];
    int rdCount[LANES];
    int expIdx[LANES];
    int validCycles[LANES];
    int lastHs[LANES];
    int prevHs[LANES];
    int cycle = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_byte_packer #(.BYTES(BYTES), .RD_LAT(0), .TIMEOUT(16)) dut0 (
        .clk            (clk),
        .rst            (rst),
        .fifo_is_empty  (fifoEmpty[0]),
        .fifo_read_data (fifoData[0]),
        .fifo_read_ctrl (rdCtrl[0]),
        .out_valid      (outValid[0]),
        .in_ready       (inReady),
        .out_word       (outWord[0]),
        .out_bytes      (outBytes[0])
    );

    fifo_byte_packer #(.BYTES(BYTES), .RD_LAT(1), .TIMEOUT(16)) dut1 (
        .clk            (clk),
        .rst            (rst),
        .fifo_is_empty  (fifoEmpty[1]),
        .fifo_read_data (fifoData[1]),
        .fifo_read_ctrl (rdCtrl[1]),
        .out_valid      (outValid[1]),
        .in_ready       (inReady),
        .out_word       (outWord[1]),
        .out_bytes      (outBytes[1])
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        stimQ.push_back(b);
    endtask

    task automatic expectWord(input logic [31:0] w, input logic [2:0] nb);
        expWordQ.push_back(w);
        expBytesQ.push_back(nb);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((expIdx[0] < int'(expWordQ.size()) || expIdx[1] < int'(expWordQ.size())) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        for (int i = 0; i < LANES; i++)
            checkOutput($sformatf("lane%0d words delivered", i), 64'(expIdx[i]), 64'(expWordQ.size()));
    endtask

    // Behavioural FIFOs: reads seen before an edge pop on that edge; RD_LAT=1 presents data after it.
    initial begin : fifoModel
        logic [LANES-1:0] rdSeen;
        fifoEmpty = '1;
        fifoData  = '0;
        for (int i = 0; i < LANES; i++) begin
            rdPtr[i]   = 0;
            rdCount[i] = 0;
        end
        forever begin
            @(negedge clk);
            rdSeen = rdCtrl;
            for (int i = 0; i < LANES; i++)
                if (rdSeen[i]) checkOutput($sformatf("lane%0d read while empty", i), 64'(fifoEmpty[i]), 64'd0);
            @(posedge clk);
            #1;
            for (int i = 0; i < LANES; i++) begin
                if (rdSeen[i]) begin
                    if (i == 1) fifoData[i] = (rdPtr[i] < int'(stimQ.size())) ? stimQ[rdPtr[i]] : 8'h00;
                    rdPtr[i]++;
                    rdCount[i]++;
                end
                if (rdPtr[i] < discardPtr) rdPtr[i] = discardPtr;
                fifoEmpty[i] = (rdPtr[i] >= int'(stimQ.size())) || (gapMode && $urandom_range(0, 2) == 0);
                if (i == 0) fifoData[i] = (rdPtr[i] < int'(stimQ.size())) ? stimQ[rdPtr[i]] : 8'h00;
            end
        end
    end

    // Monitor: compares every handshaken word with the scoreboard and checks stability under backpressure.
    initial begin : monitor
        logic [LANES-1:0]       held;
        logic [LANES-1:0][31:0] heldWord;
        logic [LANES-1:0][2:0]  heldBytes;
        held = '0;
        heldWord = '0;
        heldBytes = '0;
        for (int i = 0; i < LANES; i++) begin
            expIdx[i]      = 0;
            validCycles[i] = 0;
            lastHs[i]      = 0;
            prevHs[i]      = 0;
        end
        forever begin
            @(negedge clk);
            cycle++;
            for (int i = 0; i < LANES; i++) begin
                if (rst) begin
                    held[i] = 1'b0;
                    continue;
                end
                if (held[i]) begin
                    checkOutput($sformatf("lane%0d held valid", i), 64'(outValid[i]), 64'd1);
                    checkOutput($sformatf("lane%0d held word", i), 64'(outWord[i]), 64'(heldWord[i]));
                    checkOutput($sformatf("lane%0d held bytes", i), 64'(outBytes[i]), 64'(heldBytes[i]));
                end
                if (!outValid[i]) checkOutput($sformatf("lane%0d idle out_bytes", i), 64'(outBytes[i]), 64'd0);
                if (outValid[i]) validCycles[i]++;
                if (outValid[i] && inReady) begin
                    if (expIdx[i] < int'(expWordQ.size())) begin
                        checkOutput($sformatf("lane%0d word %0d", i, expIdx[i]), 64'(outWord[i]), 64'(expWordQ[expIdx[i]]));
                        checkOutput($sformatf("lane%0d bytes %0d", i, expIdx[i]), 64'(outBytes[i]), 64'(expBytesQ[expIdx[i]]));
                    end else begin
                        checkOutput($sformatf("lane%0d unexpected word count", i), 64'(expIdx[i] + 1), 64'(expWordQ.size()));
                    end
                    expIdx[i]++;
                    prevHs[i] = lastHs[i];
                    lastHs[i] = cycle;
                end
                held[i]      = outValid[i] && !inReady;
                heldWord[i]  = outWord[i];
                heldBytes[i] = outBytes[i];
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int snap[LANES];
        logic [31:0] w;
        rst     = 1'b1;
        inReady = 1'b0;
        w       = '0;

        // Reset with a non-empty FIFO: no reads, outputs cleared; the FIFO resets alongside.
        applyStimulus(8'h5A);
        applyStimulus(8'hA5);
        waitCycles(2);
        @(negedge clk);
        for (int i = 0; i < LANES; i++) begin
            checkOutput($sformatf("lane%0d reset read_ctrl", i), 64'(rdCtrl[i]), 64'd0);
            checkOutput($sformatf("lane%0d reset valid", i), 64'(outValid[i]), 64'd0);
            checkOutput($sformatf("lane%0d reset word", i), 64'(outWord[i]), 64'd0);
            checkOutput($sformatf("lane%0d reset bytes", i), 64'(outBytes[i]), 64'd0);
        end
        discardPtr = stimQ.size();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < LANES; i++) begin
            checkOutput($sformatf("lane%0d post-reset read_ctrl", i), 64'(rdCtrl[i]), 64'd0);
            checkOutput($sformatf("lane%0d post-reset valid", i), 64'(outValid[i]), 64'd0);
            checkOutput($sformatf("lane%0d post-reset word", i), 64'(outWord[i]), 64'd0);
        end
        waitCycles(1);

        // One full word with the sink always ready: valid for exactly one cycle.
        $display("[TB] full word");
        inReady = 1'b1;
        for (int i = 0; i < LANES; i++) snap[i] = validCycles[i];
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h44);
        expectWord(32'h44332211, 3'd4);
        waitDrain(40);
        waitCycles(3);
        for (int i = 0; i < LANES; i++)
            checkOutput($sformatf("lane%0d valid cycles", i), 64'(validCycles[i] - snap[i]), 64'd1);

        // Backpressure: only the first word is read while the sink stalls; then the next follows at full rate.
        $display("[TB] backpressure");
        inReady = 1'b0;
        for (int i = 0; i < LANES; i++) snap[i] = rdCount[i];
        for (int k = 1; k <= 8; k++) applyStimulus(8'(k));
        expectWord(32'h04030201, 3'd4);
        expectWord(32'h08070605, 3'd4);
        waitCycles(12);
        for (int i = 0; i < LANES; i++) begin
            checkOutput($sformatf("lane%0d reads under stall", i), 64'(rdCount[i] - snap[i]), 64'd4);
            checkOutput($sformatf("lane%0d valid under stall", i), 64'(outValid[i]), 64'd1);
        end
        inReady = 1'b1;
        waitDrain(40);
        checkOutput("lane0 word spacing", 64'(lastHs[0] - prevHs[0]), 64'd4);
        checkOutput("lane1 word spacing", 64'(lastHs[1] - prevHs[1]), 64'd5);

        // Random FIFO-empty gaps over 100 bytes: order preserved, never a read while empty.
        $display("[TB] empty gaps");
        gapMode = 1'b1;
        for (int k = 0; k < 100; k++) begin
            logic [7:0] b;
            b = 8'((k * 37 + 5) & 255);
            applyStimulus(b);
            w[8*(k%4) +: 8] = b;
            if (k % 4 == 3) expectWord(w, 3'd4);
        end
        waitDrain(1500);
        gapMode = 1'b0;
        waitCycles(2);

        // Reset mid-word (RD_LAT=1 lane has a byte in flight): partial data is discarded.
        $display("[TB] reset mid-word");
        applyStimulus(8'hC1); applyStimulus(8'hC2); applyStimulus(8'hC3);
        waitCycles(2);
        rst = 1'b1;
        discardPtr = stimQ.size();
        waitCycles(1);
        rst = 1'b0;
        waitCycles(1);
        applyStimulus(8'hD1); applyStimulus(8'hD2); applyStimulus(8'hD3); applyStimulus(8'hD4);
        expectWord(32'hD4D3D2D1, 3'd4);
        waitDrain(40);

`ifdef FIFO_PACKER_TIMEOUT_EN
        // Partial word flushed after the idle timeout with out_bytes equal to the bytes held.
        $display("[TB] timeout flush");
        applyStimulus(8'hAA); applyStimulus(8'hBB); applyStimulus(8'hCC);
        expectWord(32'h00CCBBAA, 3'd3);
        waitCycles(12);
        for (int i = 0; i < LANES; i++)
            checkOutput($sformatf("lane%0d early flush", i), 64'(outValid[i]), 64'd0);
        waitDrain(60);
`else
        // Without the idle flush a partial word waits until the missing byte arrives.
        $display("[TB] partial word wait");
        applyStimulus(8'hAA); applyStimulus(8'hBB); applyStimulus(8'hCC);
        waitCycles(30);
        for (int i = 0; i < LANES; i++)
            checkOutput($sformatf("lane%0d partial valid", i), 64'(outValid[i]), 64'd0);
        applyStimulus(8'hDD);
        expectWord(32'hDDCCBBAA, 3'd4);
        waitDrain(40);
`endif

        waitCycles(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
